a2d_arb: RTL and testbench
==========================

# a2d_arb

Round-robin arbiter and sequencer that shares the single `A2D_intf` SPI converter among up to `NREQ` requesters, such as the slider/pot scanner, a battery monitor or a test port. It accepts per-requester channel requests and drives the converter's `chnnl`/`strt_cnv` handshake, one conversion at a time. It returns the 12-bit result to the winning requester with a done pulse, and flags conversions whose `cnv_cmplt` never arrives.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `CH_W`, default 3: channel field width.
- `RES_W`, default 12: result width.
- `TMO`, default 4096: WAIT-state cycle limit before a timeout is declared.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  NREQ: per-requester conversion request. Level signal, held until `done`.
- `req_chnnl`  in  NREQ*CH_W: channel per requester. Requester i occupies bits `[i*CH_W +: CH_W]`.
- `gnt`  out  NREQ: one-hot, 1-cycle pulse when requester i's conversion is launched.
- `done`  out  NREQ: one-hot, 1-cycle pulse when requester i's result (or error) is valid.
- `rd_data`  out  RES_W: result, valid while `done` is high. Holds its value until the next `done`.
- `tmo_err`  out  1: high with `done` when the conversion timed out. `rd_data` is 0 in that case.
- `chnnl`  out  CH_W: channel to `A2D_intf`, registered, stable from START through WAIT.
- `strt_cnv`  out  1: start pulse to `A2D_intf`, exactly 1 cycle.
- `cnv_cmplt`  in  1: conversion-complete from `A2D_intf`.
- `res`  in  RES_W: result from `A2D_intf`, sampled in the cycle `cnv_cmplt` is high.

## Operation
- States: IDLE, START, WAIT, DONE. Reset state is IDLE.
- **IDLE**
  - If `|req`, the winner is the lowest index ≥ `rr_ptr` with `req` high, wrapping modulo NREQ.
  - Register `sel`<=winner and `chnnl`<=`req_chnnl[sel]`, then go to START.
  - If no request, stay in IDLE.
- **START**
  - Assert `strt_cnv`=1 and `gnt[sel]`=1 for this cycle only.
  - Clear the timeout counter and go to WAIT.
- **WAIT**
  - Sample `cnv_cmplt` only in this state.
  - When `cnv_cmplt`=1: `rd_data`<=`res`, `tmo_err`<=0, go to DONE.
  - Else, if the counter equals `TMO-1`: `rd_data`<=0, `tmo_err`<=1, go to DONE.
  - Else increment the counter.
- **DONE**
  - `done[sel]`=1 for one cycle.
  - `rr_ptr`<=(`sel`+1) mod NREQ.
  - Go to IDLE.
- `chnnl` is not changed outside IDLE→START, so the channel is stable for the whole conversion.
- Dropping `req` after `gnt` does not abort the conversion. It completes and `done` still pulses.
- A requester still asserting `req` after its `done` re-enters arbitration. Rotation guarantees every other active requester is served first.
- `req` and `req_chnnl` changes while not in IDLE are ignored until the next IDLE cycle.
- Reset values: `gnt`=0, `done`=0, `rd_data`=0, `tmo_err`=0, `chnnl`=0, `strt_cnv`=0, `rr_ptr`=0, `sel`=0, counter=0.
- Reset mid-conversion returns to IDLE immediately with all outputs at their reset values. No `done` is issued for the aborted conversion.

## Timing
- All outputs are registered.
- `req` rising in IDLE at cycle 0 gives `strt_cnv`/`gnt` at cycle 1, with `chnnl` already valid at cycle 1.
- `cnv_cmplt` at WAIT cycle k gives `done`/`rd_data` at cycle k+1.
- After `done`, there is one mandatory IDLE cycle before the next `strt_cnv`.
- Minimum period from one `strt_cnv` to the next is converter latency + 3 cycles.
- `cnv_cmplt` high during START or IDLE is ignored. A stale pulse from a previous conversion must not complete the current one.
- Timeout: `done` with `tmo_err`=1 occurs exactly `TMO`+1 cycles after `strt_cnv`.
- Simultaneous `cnv_cmplt` and counter=`TMO-1`: completion wins and `tmo_err`=0.

## Structure
- Package `a2d_arb_pkg` holds:
  - state enum `arb_state_t` {IDLE, START, WAIT, DONE};
  - default widths `A2D_CH_W`=3 and `A2D_RES_W`=12;
  - the default `TMO`.
- Sub-module `rr_pick` is combinational: inputs `req[NREQ]` and `ptr`, outputs `valid` and `idx`. It is reusable by other arbiters.
- `A2D_intf` is instantiated by the parent, not inside `a2d_arb`.

## Test plan
- **Single requester:** `req[2]`=1, channel 5, converter model returns 0xABC after 40 cycles.
  - Expect `strt_cnv` 1 cycle after `req` and `chnnl`=5.
  - Expect `done`=4'b0100 and `rd_data`=0xABC exactly 1 cycle after `cnv_cmplt`.
- **All four requesting continuously from reset:** `gnt` order is 0,1,2,3,0,1.
  - Each `done` carries that requester's channel-tagged result (model returns 0x100+chnnl).
- **Stale/early complete:** pulse `cnv_cmplt` during START.
  - Expect no `done` that cycle; state stays WAIT until the real `cnv_cmplt`.
- **Timeout:** converter model never completes, `TMO`=16.
  - Expect `done[sel]` with `tmo_err`=1 and `rd_data`=0 exactly 17 cycles after `strt_cnv`.
  - Next arbitration then proceeds normally.
- **Reset mid-WAIT:** assert `rst` 10 cycles after `strt_cnv`.
  - All outputs go to 0 asynchronously and no `done` is issued.
  - After release, a pending `req[1]` is granted first (`rr_ptr`=0, `req[0]`=0).
- **Requester drops `req` after `gnt`:** `done` is still pulsed with the valid result, and no re-grant occurs.

Source files
------------

// File: rtl/a2d_arb_pkg.sv
// rtl/a2d_arb_pkg.sv - shared types and defaults for the A2D arbiter
package a2d_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam int A2D_CH_W  = 3;
   localparam int A2D_RES_W = 12;
   localparam int A2D_TMO   = 4096;

   // Index width that stays at least 1 bit for degenerate sizes.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/a2d_arb_rr_pick.sv
// rtl/a2d_arb_rr_pick.sv - combinational round-robin pick: lowest active index at or after ptr
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic            valid_o,
   output logic [IW-1:0]   idx_o
);

   int j;

   // Scan offsets from the far end so the closest offset to ptr wins last.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      j       = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (int'(ptr_i) + k) % NREQ;
         if (req_i[IW'(j)]) begin
            valid_o = 1'b1;
            idx_o   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/a2d_arb.sv
// rtl/a2d_arb.sv - round-robin sequencer sharing one A2D converter among NREQ requesters
module a2d_arb
   import a2d_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int CH_W  = A2D_CH_W,
   parameter int RES_W = A2D_RES_W,
   parameter int TMO   = A2D_TMO
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ*CH_W-1:0] req_chnnl_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [NREQ-1:0]      done_o,
   output logic [RES_W-1:0]     rd_data_o,
   output logic                 tmo_err_o,
   output logic [CH_W-1:0]      chnnl_o,
   output logic                 strt_cnv_o,
   input  logic                 cnv_cmplt_i,
   input  logic [RES_W-1:0]     res_i
);

   localparam int IW = idx_w(NREQ);
   localparam int CW = idx_w(TMO);

   arb_state_t       state_q, state_d;
   logic [IW-1:0]    sel_q, sel_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CH_W-1:0]  chnnl_q, chnnl_d;
   logic [RES_W-1:0] rd_data_q, rd_data_d;
   logic             tmo_err_q, tmo_err_d;
   logic             strt_q, strt_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  done_q, done_d;

   logic             pick_valid;
   logic [IW-1:0]    pick_idx;
   logic             cnt_last;
   logic [NREQ-1:0]  pick_hot;
   logic [NREQ-1:0]  sel_hot;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .req_i   (req_i),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign cnt_last = (cnt_q == CW'(TMO - 1));
   assign pick_hot = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
   assign sel_hot  = {{(NREQ-1){1'b0}}, 1'b1} << sel_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pick_valid) state_d = START;
         START:   state_d = WAIT;
         WAIT:    if (cnv_cmplt_i || cnt_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next-values are computed one cycle early so every port is a flop.
   always_comb begin
      sel_d     = sel_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      chnnl_d   = chnnl_q;
      rd_data_d = rd_data_q;
      tmo_err_d = tmo_err_q;
      strt_d    = 1'b0;
      gnt_d     = '0;
      done_d    = '0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               sel_d   = pick_idx;
               chnnl_d = req_chnnl_i[int'(pick_idx)*CH_W +: CH_W];
               strt_d  = 1'b1;
               gnt_d   = pick_hot;
            end
         end
         START: begin
            cnt_d = '0;
         end
         WAIT: begin
            // Completion takes priority over a coincident timeout.
            if (cnv_cmplt_i) begin
               rd_data_d = res_i;
               tmo_err_d = 1'b0;
               done_d    = sel_hot;
            end else if (cnt_last) begin
               rd_data_d = '0;
               tmo_err_d = 1'b1;
               done_d    = sel_hot;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            rr_ptr_d = (sel_q == IW'(NREQ - 1)) ? '0 : sel_q + IW'(1);
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sel_q     <= '0;
         rr_ptr_q  <= '0;
         cnt_q     <= '0;
         chnnl_q   <= '0;
         rd_data_q <= '0;
         tmo_err_q <= 1'b0;
         strt_q    <= 1'b0;
         gnt_q     <= '0;
         done_q    <= '0;
      end else begin
         sel_q     <= sel_d;
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
         chnnl_q   <= chnnl_d;
         rd_data_q <= rd_data_d;
         tmo_err_q <= tmo_err_d;
         strt_q    <= strt_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
      end
   end

   assign gnt_o      = gnt_q;
   assign done_o     = done_q;
   assign rd_data_o  = rd_data_q;
   assign tmo_err_o  = tmo_err_q;
   assign chnnl_o    = chnnl_q;
   assign strt_cnv_o = strt_q;

endmodule

// File: tb/tb_a2d_arb.sv
// tb/tb_a2d_arb.sv - directed bench for a2d_arb
module tb_a2d_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] req_chnnl;
   logic [3:0]  gnt, done;
   logic [11:0] rd_data;
   logic        tmo_err;
   logic [2:0]  chnnl;
   logic        strt;
   logic        cnv;
   logic [11:0] res;

   logic [3:0]  t_req;
   logic [11:0] t_req_chnnl;
   logic [3:0]  t_gnt, t_done;
   logic [11:0] t_rd_data;
   logic        t_tmo_err;
   logic [2:0]  t_chnnl;
   logic        t_strt;
   logic        t_cnv;
   logic [11:0] t_res;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   a2d_arb #(.NREQ(4), .CH_W(3), .RES_W(12), .TMO(64)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .req_chnnl_i (req_chnnl),
      .gnt_o       (gnt),
      .done_o      (done),
      .rd_data_o   (rd_data),
      .tmo_err_o   (tmo_err),
      .chnnl_o     (chnnl),
      .strt_cnv_o  (strt),
      .cnv_cmplt_i (cnv),
      .res_i       (res)
   );

   a2d_arb #(.NREQ(4), .CH_W(3), .RES_W(12), .TMO(16)) dut_t (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (t_req),
      .req_chnnl_i (t_req_chnnl),
      .gnt_o       (t_gnt),
      .done_o      (t_done),
      .rd_data_o   (t_rd_data),
      .tmo_err_o   (t_tmo_err),
      .chnnl_o     (t_chnnl),
      .strt_cnv_o  (t_strt),
      .cnv_cmplt_i (t_cnv),
      .res_i       (t_res)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_strt(input string tag, output int n);
      n = 0;
      while (strt !== 1'b1 && n < 200) begin
         tick;
         n++;
      end
      chk(tag, {31'd0, strt}, 32'd1);
   endtask

   initial begin
      logic [3:0] seen;
      logic       seen_s;
      int         n;
      int         exp_idx;
      logic [2:0] exp_ch;

      rst = 1'b1; req = '0; req_chnnl = '0; cnv = 1'b0; res = '0;
      t_req = '0; t_req_chnnl = '0; t_cnv = 1'b0; t_res = '0;
      tick; tick;
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_rd", rd_data, 0);
      chk("rst_tmo", tmo_err, 0);
      chk("rst_chnnl", chnnl, 0);
      chk("rst_strt", strt, 0);
      rst = 1'b0;
      tick;

      // single requester 2, channel 5, result 0xABC
      req_chnnl = 12'(5) << 6;
      req = 4'b0100;
      tick;
      chk("s1_strt", strt, 1);
      chk("s1_gnt", gnt, 4'b0100);
      chk("s1_chnnl", chnnl, 5);
      seen = '0;
      for (int i = 0; i < 40; i++) begin
         tick;
         seen |= done;
      end
      chk("s1_no_early_done", seen, 0);
      cnv = 1'b1; res = 12'hABC;
      tick;
      chk("s1_done", done, 4'b0100);
      chk("s1_rd", rd_data, 12'hABC);
      chk("s1_tmo", tmo_err, 0);
      cnv = 1'b0; req = '0;
      tick;
      chk("s1_done_fall", done, 0);
      chk("s1_rd_hold", rd_data, 12'hABC);

      // all four from reset: order 0,1,2,3,0,1 with result 0x100+channel
      rst = 1'b1;
      req_chnnl = {3'd4, 3'd3, 3'd2, 3'd1};
      req = 4'b1111;
      tick;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         exp_idx = i % 4;
         exp_ch  = 3'(exp_idx + 1);
         wait_strt("rr_strt", n);
         if (i == 1) chk("rr_idle_gap", n, 2);
         chk("rr_gnt", gnt, 4'b0001 << exp_idx);
         chk("rr_chnnl", chnnl, exp_ch);
         tick; tick;
         cnv = 1'b1; res = 12'h100 + 12'(exp_ch);
         tick;
         chk("rr_done", done, 4'b0001 << exp_idx);
         chk("rr_rd", rd_data, 12'h100 + 12'(exp_ch));
         cnv = 1'b0;
         if (i == 5) req = '0;
      end
      tick;

      // stale complete during IDLE and START is ignored
      req_chnnl = 12'd6;
      req = 4'b0001;
      cnv = 1'b1; res = 12'h111;
      tick;
      chk("st_strt", strt, 1);
      chk("st_gnt", gnt, 4'b0001);
      tick;
      chk("st_no_done", done, 0);
      cnv = 1'b0;
      seen = '0;
      tick; seen |= done;
      tick; seen |= done;
      chk("st_wait_hold", seen, 0);
      cnv = 1'b1; res = 12'h5A5;
      tick;
      chk("st_done", done, 4'b0001);
      chk("st_rd", rd_data, 12'h5A5);
      cnv = 1'b0; req = '0;
      tick;

      // reset ten cycles into a conversion
      req_chnnl = 12'(5) << 6;
      req = 4'b0100;
      tick;
      chk("rw_strt", strt, 1);
      for (int i = 0; i < 10; i++) tick;
      chk("rw_chnnl_busy", chnnl, 5);
      rst = 1'b1;
      #1;
      chk("rw_async_chnnl", chnnl, 0);
      chk("rw_async_rd", rd_data, 0);
      chk("rw_async_done", done, 0);
      chk("rw_async_gnt", gnt, 0);
      req_chnnl = (12'(5) << 6) | (12'(3) << 3);
      req = 4'b0110;
      seen = '0;
      tick; seen |= done;
      tick; seen |= done;
      chk("rw_no_done", seen, 0);
      rst = 1'b0;
      tick;
      chk("rw_gnt_first", gnt, 4'b0010);
      chk("rw_chnnl", chnnl, 3);
      tick;
      cnv = 1'b1; res = 12'h321;
      tick;
      chk("rw_done", done, 4'b0010);
      chk("rw_rd", rd_data, 12'h321);
      cnv = 1'b0;
      req = 4'b0100;

      // requester 2 drops req right after its grant
      tick;
      tick;
      chk("dr_gnt", gnt, 4'b0100);
      req = '0;
      tick; tick;
      cnv = 1'b1; res = 12'h777;
      tick;
      chk("dr_done", done, 4'b0100);
      chk("dr_rd", rd_data, 12'h777);
      cnv = 1'b0;
      seen_s = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         seen_s |= strt;
      end
      chk("dr_no_regrant", seen_s, 0);

      // timeout with TMO=16
      t_req_chnnl = (12'(7) << 9) | 12'(2);
      t_req = 4'b0001;
      tick;
      chk("to_pre_strt", t_strt, 1);
      tick; tick;
      t_cnv = 1'b1; t_res = 12'hFFF;
      tick;
      chk("to_pre_rd", t_rd_data, 12'hFFF);
      t_cnv = 1'b0;
      t_req = 4'b1000;
      tick; tick;
      chk("to_strt", t_strt, 1);
      chk("to_gnt", t_gnt, 4'b1000);
      seen = '0;
      for (int i = 0; i < 16; i++) begin
         tick;
         seen |= t_done;
      end
      chk("to_no_early", seen, 0);
      tick;
      chk("to_done", t_done, 4'b1000);
      chk("to_err", t_tmo_err, 1);
      chk("to_rd", t_rd_data, 0);
      t_req = 4'b0001;
      tick; tick;
      chk("to_next_gnt", t_gnt, 4'b0001);
      for (int i = 0; i < 16; i++) tick;
      t_cnv = 1'b1; t_res = 12'h0AB;
      tick;
      chk("to_tie_done", t_done, 4'b0001);
      chk("to_tie_err", t_tmo_err, 0);
      chk("to_tie_rd", t_rd_data, 12'h0AB);
      t_cnv = 1'b0; t_req = '0;
      tick;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
